polyphase_dec_ctrl: RTL and testbench
=====================================

// Module: polyphase_dec_ctrl
// PURPOSE
//  Single-clock sequencer for the 2:1 polyphase decimator of the Daubechies-3 analysis bank.
//  Replaces the clk1/clk2 pair with enables: steers input samples into odd/even lane registers,
//  advances the polyphase filters once per sample pair, primes and flushes the filter pipeline,
//  and presents a valid/ready output strobe to the next stage.
// PARAMETERS
//  FILT_LAT     3   pair_en pulses needed after start before filter output is valid (db3: 3 taps/phase)
//  FLUSH_PAIRS  2   zero-sample pairs injected after stop to drain the filter tail
//  CNT_W        16  width of pair_cnt
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      1-cycle request: IDLE -> RUN
//  stop       in   1      1-cycle request: RUN -> FLUSH
//  in_valid   in   1      upstream sample present
//  in_ready   out  1      sample accepted when in_valid & in_ready
//  ld_odd     out  1      load x1 lane (first sample of pair), combinational from acceptance
//  ld_even    out  1      load x0 lane (second sample of pair), combinational from acceptance
//  zero_fill  out  1      lane mux selects 16'd0 instead of input (FLUSH only)
//  pair_en    out  1      registered 1-cycle pulse: advance both polyphase filters
//  out_valid  out  1      decimated output pair valid
//  out_ready  in   1      downstream accepts on out_valid & out_ready
//  busy       out  1      state != IDLE
//  done       out  1      1-cycle pulse on FLUSH -> IDLE
//  overrun    out  1      sticky: in_valid seen while state != RUN; cleared by accepted start
//  pair_cnt   out  CNT_W  pair_en pulses since last start, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state IDLE, phase=ODD, all outputs 0, prime counter 0.
//  States IDLE, RUN, FLUSH. start in IDLE -> RUN, clears pair_cnt, prime cnt, overrun, phase=ODD.
//   start outside IDLE ignored; stop outside RUN ignored; start&stop together in IDLE: stay IDLE.
//  Phase: each accepted sample toggles phase; ODD acceptance asserts ld_odd, EVEN asserts ld_even.
//  Pair: EVEN acceptance at cycle t -> pair_en=1 at t+1, pair_cnt++ at t+1.
//  Priming: prime cnt saturates at FILT_LAT; out_valid set at the cycle after a pair_en
//   that brings prime cnt to FILT_LAT or later; no out_valid for the first FILT_LAT-1 pairs.
//  out_valid held until out_valid&out_ready; clear and new set in same cycle -> stays 1.
//  Backpressure: in_ready = (RUN|FLUSH) & !(phase==EVEN & out_valid & !out_ready).
//   ODD samples never stall; a pair never completes while an unaccepted output is held.
//  In FLUSH, in_ready drives internal zero samples (one per cycle, same stall rule); zero_fill=1;
//   external in_valid ignored (sets overrun).
//  stop in RUN: -> FLUSH. If phase==EVEN (half pair held), one zero completes it first; then
//   FLUSH_PAIRS full zero pairs. After last flush pair_en and its out_valid accepted -> IDLE, done=1.
//  rst_n low mid-operation: immediate return to reset values; lane contents are don't-care.
//  pair_cnt wraps 2^CNT_W-1 -> 0 without side effect.
// STRUCTURE
//  Package polyphase_dec_pkg: state encoding (IDLE/RUN/FLUSH), phase constants ODD=1'b1/EVEN=1'b0,
//   DATA_W=16 shared with lane registers.
//  One sub-module: dec_prime_cnt (saturating prime counter + pair_cnt, inputs clr/inc).
//  FSM, phase bit, handshake logic in top.
// TESTING
//  T1 reset: rst_n=0 mid-RUN -> next edge all outputs 0, busy=0; release, start -> first ld is ld_odd.
//  T2 stream: start, 8 back-to-back samples, out_ready=1 -> ld_odd/ld_even alternate,
//   4 pair_en pulses each 1 cycle after ld_even, out_valid only after pulses 3 and 4, pair_cnt=4.
//  T3 backpressure: out_ready=0 with out_valid=1 -> in_ready drops only at EVEN phase;
//   raise out_ready -> accept resumes same cycle, no sample lost or duplicated.
//  T4 stop odd: stop after 3 samples -> 1 zero_fill load completes pair, then 2 zero pairs,
//   total 4 pair_en, done pulse, IDLE; stop after 4 samples -> exactly 2 zero pairs.
//  T5 corner cases: start&stop same cycle in IDLE -> stays IDLE; in_valid in IDLE -> overrun=1
//   until next start; CNT_W=4, 17 pairs -> pair_cnt=1.

Source files
------------

// File: rtl/polyphase_dec_pkg.sv
// Shared types and constants for the db3 polyphase decimator sequencer.
package polyphase_dec_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned FILT_LAT    = 3;
    localparam int unsigned FLUSH_PAIRS = 2;
    localparam int unsigned CNT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic PH_ODD  = 1'b1;
    localparam logic PH_EVEN = 1'b0;

endpackage

// File: rtl/polyphase_dec_ctrl_if.sv
// Sample/lane/output handshake bundle between the sequencer and the datapath.
interface polyphase_dec_ctrl_if;

    logic in_valid;
    logic in_ready;
    logic ld_odd;
    logic ld_even;
    logic zero_fill;
    logic pair_en;
    logic out_valid;
    logic out_ready;

    modport master (
        input  in_valid, out_ready,
        output in_ready, ld_odd, ld_even, zero_fill, pair_en, out_valid
    );

    modport slave (
        output in_valid, out_ready,
        input  in_ready, ld_odd, ld_even, zero_fill, pair_en, out_valid
    );

endinterface

// File: rtl/dec_prime_cnt.sv
// Saturating filter-priming counter plus free-running (wrapping) pair counter.
module dec_prime_cnt #(
    parameter int unsigned FILT_LAT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic             primed,
    output logic [CNT_W-1:0] pair_cnt
);

    localparam int unsigned PRIME_W = $clog2(FILT_LAT + 1);

    logic [PRIME_W-1:0] prime_q, prime_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        prime_d = prime_q;
        cnt_d   = cnt_q;
        if (clr) begin
            prime_d = '0;
            cnt_d   = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (prime_q != PRIME_W'(FILT_LAT)) begin
                prime_d = prime_q + PRIME_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_q <= '0;
            cnt_q   <= '0;
        end else begin
            prime_q <= prime_d;
            cnt_q   <= cnt_d;
        end
    end

    assign primed   = (prime_q == PRIME_W'(FILT_LAT));
    assign pair_cnt = cnt_q;

endmodule

// File: rtl/polyphase_dec_ctrl.sv
// Single-clock sequencer for the 2:1 db3 polyphase decimator: lane steering,
// pair advance, pipeline prime/flush and output valid/ready.
module polyphase_dec_ctrl
    import polyphase_dec_pkg::*;
#(
    parameter int unsigned FILT_LAT    = polyphase_dec_pkg::FILT_LAT,
    parameter int unsigned FLUSH_PAIRS = polyphase_dec_pkg::FLUSH_PAIRS,
    parameter int unsigned CNT_W       = polyphase_dec_pkg::CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    polyphase_dec_ctrl_if.master       bus,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun,
    output logic [CNT_W-1:0]           pair_cnt
);

    localparam int unsigned ZCNT_W = $clog2(2 * FLUSH_PAIRS + 2);

    state_e              state_q, state_d;
    logic                phase_q, phase_d;
    logic [ZCNT_W-1:0]   zleft_q, zleft_d;
    logic                pair_en_q, pair_en_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                zero_fill_q, zero_fill_d;

    logic                start_acc_c;
    logic                hold_c;
    logic                in_ready_c;
    logic                acc_c;
    logic                ld_odd_c;
    logic                ld_even_c;
    logic                primed;

    // Acceptance: an EVEN sample may not complete a pair while an output is held.
    always_comb begin
        start_acc_c = start && !stop && (state_q == ST_IDLE);
        hold_c      = (phase_q == PH_EVEN) && out_valid_q && !bus.out_ready;
        in_ready_c  = ((state_q == ST_RUN) ||
                       ((state_q == ST_FLUSH) && (zleft_q != '0))) && !hold_c;
        acc_c       = in_ready_c && ((state_q == ST_FLUSH) || bus.in_valid);
        ld_odd_c    = acc_c && (phase_q == PH_ODD);
        ld_even_c   = acc_c && (phase_q == PH_EVEN);
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        zleft_d     = zleft_q;
        done_d      = 1'b0;
        pair_en_d   = ld_even_c;
        out_valid_d = (pair_en_q && primed) || (out_valid_q && !bus.out_ready);
        overrun_d   = overrun_q || (bus.in_valid && (state_q != ST_RUN));

        if (acc_c) begin
            phase_d = ~phase_q;
        end
        if (start_acc_c) begin
            phase_d   = PH_ODD;
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_acc_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A half-held pair gets one extra zero before the full flush pairs.
                if (stop) begin
                    state_d = ST_FLUSH;
                    zleft_d = ZCNT_W'(2 * FLUSH_PAIRS) + ZCNT_W'(phase_d == PH_EVEN);
                end
            end
            ST_FLUSH: begin
                if ((zleft_q == '0) && !pair_en_q && (!out_valid_q || bus.out_ready)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (acc_c) begin
                    zleft_d = zleft_q - ZCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        zero_fill_d = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_ODD;
            zleft_q     <= '0;
            pair_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            zero_fill_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            zleft_q     <= zleft_d;
            pair_en_q   <= pair_en_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            zero_fill_q <= zero_fill_d;
        end
    end

    dec_prime_cnt #(
        .FILT_LAT (FILT_LAT),
        .CNT_W    (CNT_W)
    ) u_prime_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_acc_c),
        .inc      (ld_even_c),
        .primed   (primed),
        .pair_cnt (pair_cnt)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.ld_odd    = ld_odd_c;
    assign bus.ld_even   = ld_even_c;
    assign bus.zero_fill = zero_fill_q;
    assign bus.pair_en   = pair_en_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_polyphase_dec_ctrl.sv
// Self-checking bench: per-cycle model of the sequencing rules plus directed literal checks.
module tb_polyphase_dec_ctrl;

    localparam int LAT = 3;
    localparam int FP  = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic        busy, done, overrun;
    logic [15:0] pair_cnt;
    logic        busy4, done4, overrun4;
    logic [3:0]  pair_cnt4;

    int errors = 0;
    int checks = 0;

    polyphase_dec_ctrl_if ifc ();
    polyphase_dec_ctrl_if ifc4 ();

    assign ifc4.in_valid  = ifc.in_valid;
    assign ifc4.out_ready = ifc.out_ready;

    always #5 clk = ~clk;

    polyphase_dec_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .bus      (ifc),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun),
        .pair_cnt (pair_cnt)
    );

    polyphase_dec_ctrl #(.CNT_W(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .bus      (ifc4),
        .busy     (busy4),
        .done     (done4),
        .overrun  (overrun4),
        .pair_cnt (pair_cnt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state as plain integers, evaluated on each falling edge.
    int m_st, m_pairs, m_zl;
    bit m_odd, m_pe, m_ov, m_done, m_ovr;

    initial begin : model_check
        bit ir, acc, lo, le, sacc, n_pe, n_ov, n_ovr, n_done;
        logic [8:0] ev;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_st = 0; m_odd = 1; m_pairs = 0; m_zl = 0;
                m_pe = 0; m_ov = 0; m_done = 0; m_ovr = 0;
            end
            ir  = (m_st == 1 || (m_st == 2 && m_zl > 0)) && !(!m_odd && m_ov && !ifc.out_ready);
            acc = ir && (m_st == 2 || ifc.in_valid);
            lo  = acc && m_odd;
            le  = acc && !m_odd;
            ev  = {ir, lo, le, m_st == 2, m_pe, m_ov, m_st != 0, m_done, m_ovr};
            chk("ctl", 32'({ifc.in_ready, ifc.ld_odd, ifc.ld_even, ifc.zero_fill,
                            ifc.pair_en, ifc.out_valid, busy, done, overrun}), 32'(ev));
            chk("pair_cnt", 32'(pair_cnt), 32'(m_pairs % 65536));
            chk("ctl4", 32'({ifc4.in_ready, ifc4.ld_odd, ifc4.ld_even, ifc4.zero_fill,
                             ifc4.pair_en, ifc4.out_valid, busy4, done4, overrun4}), 32'(ev));
            chk("pair_cnt4", 32'(pair_cnt4), 32'(m_pairs % 16));
            if (rst_n) begin
                sacc   = start && !stop && m_st == 0;
                n_pe   = le;
                n_ov   = (m_pe && m_pairs >= LAT) || (m_ov && !ifc.out_ready);
                n_ovr  = sacc ? 1'b0 : (m_ovr || (ifc.in_valid && m_st != 1));
                n_done = 0;
                if (acc)  m_odd = !m_odd;
                if (sacc) m_odd = 1;
                case (m_st)
                    0: if (sacc) m_st = 1;
                    1: if (stop) begin m_st = 2; m_zl = 2 * FP + (m_odd ? 0 : 1); end
                    default: begin
                        if (m_zl == 0 && !m_pe && (!m_ov || ifc.out_ready)) begin
                            m_st = 0; n_done = 1;
                        end else if (acc) begin
                            m_zl--;
                        end
                    end
                endcase
                m_pairs = sacc ? 0 : m_pairs + int'(le);
                m_pe = n_pe; m_ov = n_ov; m_ovr = n_ovr; m_done = n_done;
            end
        end
    end

    // Event tallies for the directed checks.
    int pe_n = 0, ev_n = 0, od_n = 0, zl_n = 0, dn_n = 0, oa_n = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            pe_n <= pe_n + int'(ifc.pair_en);
            ev_n <= ev_n + int'(ifc.ld_even);
            od_n <= od_n + int'(ifc.ld_odd);
            zl_n <= zl_n + int'(ifc.zero_fill && (ifc.ld_odd || ifc.ld_even));
            dn_n <= dn_n + int'(done);
            oa_n <= oa_n + int'(ifc.out_valid && ifc.out_ready);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; ifc.in_valid = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    task automatic feed(input int n);
        int got = 0;
        int guard = 0;
        ifc.in_valid = 1'b1;
        while (got < n && guard < 200) begin
            @(negedge clk);
            if (ifc.in_ready) got++;
            cyc();
            guard++;
        end
        ifc.in_valid = 1'b0;
        if (got != n) chk("feed_timeout", 32'(got), 32'(n));
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int g = 0; g < 100 && !seen; g++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        cyc();
    endtask

    int pe0, ev0, od0, zl0, dn0, oa0;
    task automatic snap();
        pe0 = pe_n; ev0 = ev_n; od0 = od_n; zl0 = zl_n; dn0 = dn_n; oa0 = oa_n;
    endtask

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;

        // T1: reset mid-RUN
        do_reset();
        ifc.out_ready = 1'b1;
        pulse_start();
        feed(3);
        chk("t1_cnt_before_rst", 32'(pair_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_busy_rst", 32'(busy), 32'd0);
        chk("t1_cnt_rst", 32'(pair_cnt), 32'd0);
        chk("t1_inready_rst", 32'(ifc.in_ready), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        pulse_start();
        ifc.in_valid = 1'b1;
        #1;
        chk("t1_first_ld", 32'({ifc.ld_odd, ifc.ld_even}), 32'b10);
        cyc();
        ifc.in_valid = 1'b0;

        // T2: back-to-back stream
        do_reset();
        ifc.out_ready = 1'b1;
        pulse_start();
        snap();
        feed(8);
        repeat (3) cyc();
        chk("t2_pair_en", 32'(pe_n - pe0), 32'd4);
        chk("t2_ld_even", 32'(ev_n - ev0), 32'd4);
        chk("t2_ld_odd", 32'(od_n - od0), 32'd4);
        chk("t2_out_acc", 32'(oa_n - oa0), 32'd2);
        chk("t2_pair_cnt", 32'(pair_cnt), 32'd4);

        // T3: backpressure stalls only the EVEN sample
        do_reset();
        ifc.out_ready = 1'b0;
        pulse_start();
        snap();
        feed(7);
        ifc.in_valid = 1'b1;
        repeat (3) cyc();
        chk("t3_stall_inready", 32'(ifc.in_ready), 32'd0);
        chk("t3_held_valid", 32'(ifc.out_valid), 32'd1);
        chk("t3_even_stalled", 32'(ev_n - ev0), 32'd3);
        ifc.out_ready = 1'b1;
        #1;
        chk("t3_resume_inready", 32'(ifc.in_ready), 32'd1);
        feed(1);
        repeat (3) cyc();
        chk("t3_ld_even", 32'(ev_n - ev0), 32'd4);
        chk("t3_ld_odd", 32'(od_n - od0), 32'd4);
        chk("t3_out_acc", 32'(oa_n - oa0), 32'd2);

        // T4a: stop with a half pair held
        do_reset();
        ifc.out_ready = 1'b1;
        pulse_start();
        snap();
        feed(3);
        pulse_stop();
        wait_done();
        chk("t4a_pair_en", 32'(pe_n - pe0), 32'd4);
        chk("t4a_zero_lds", 32'(zl_n - zl0), 32'd5);
        chk("t4a_done", 32'(dn_n - dn0), 32'd1);
        chk("t4a_out_acc", 32'(oa_n - oa0), 32'd2);
        chk("t4a_busy", 32'(busy), 32'd0);

        // T4b: stop on a pair boundary
        do_reset();
        pulse_start();
        snap();
        feed(4);
        pulse_stop();
        wait_done();
        chk("t4b_pair_en", 32'(pe_n - pe0), 32'd4);
        chk("t4b_zero_lds", 32'(zl_n - zl0), 32'd4);
        chk("t4b_done", 32'(dn_n - dn0), 32'd1);

        // T5: start&stop together, overrun, pair_cnt wrap
        do_reset();
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        cyc();
        chk("t5_startstop_busy", 32'(busy), 32'd0);
        ifc.in_valid = 1'b1;
        cyc();
        ifc.in_valid = 1'b0;
        repeat (2) cyc();
        chk("t5_overrun_set", 32'(overrun), 32'd1);
        pulse_start();
        chk("t5_overrun_clr", 32'(overrun), 32'd0);
        feed(34);
        repeat (3) cyc();
        chk("t5_pair_cnt16", 32'(pair_cnt), 32'd17);
        chk("t5_pair_cnt4", 32'(pair_cnt4), 32'd1);
        pulse_stop();
        wait_done();
        chk("t5_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
